// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler: drains four class FIFOs into one merge FIFO.
// Each class gets up to weight[k] consecutive pops per turn; almost_full stalls
// the current grant without losing credit. Popped words appear one cycle later.
module wrr_scheduler #(
    parameter int DATA_W   = 12,
    parameter int WEIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [4*WEIGHT_W-1:0] peso_in,
    input  logic [3:0]            empty,
    input  logic                  almost_full,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            pop,
    output logic [1:0]            grant_idx,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic                  idle
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        STALL
    } state_t;

    state_t              state, state_nxt;
    logic [WEIGHT_W-1:0] weight [4];
    logic [WEIGHT_W-1:0] credit, credit_nxt;
    logic [1:0]          ptr, ptr_nxt;
    logic [1:0]          cur, cur_nxt;
    logic [1:0]          sel_d;
    logic [3:0]          eligible;
    logic [1:0]          base;
    logic [1:0]          scan_idx;
    logic [1:0]          sel_idx;
    logic                sel_found;
    logic                rotate;

    // Eligibility: data present and a non-zero weight.
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            eligible[k] = !empty[k] && (weight[k] != '0);
        end
    end

    // First eligible class scanning forward from ptr (IDLE) or cur+1 (rotation).
    always_comb begin
        base      = (state == IDLE) ? ptr : cur + 2'd1;
        sel_found = 1'b0;
        sel_idx   = base;
        scan_idx  = base;
        for (int unsigned i = 0; i < 4; i++) begin
            scan_idx = base + 2'(i);
            if (!sel_found && eligible[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Next-state, credit bookkeeping and the one-hot pop.
    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur;
        credit_nxt = credit;
        ptr_nxt    = ptr;
        pop        = '0;
        rotate     = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found && !almost_full) begin
                    state_nxt  = SERVE;
                    cur_nxt    = sel_idx;
                    credit_nxt = weight[sel_idx];
                end
            end
            SERVE: begin
                if (almost_full) begin
                    state_nxt = STALL;
                end else begin
                    if (empty[cur]) begin
                        rotate = 1'b1;
                    end else begin
                        pop[cur]   = 1'b1;
                        credit_nxt = credit - WEIGHT_W'(1);
                        if (credit < WEIGHT_W'(2)) begin
                            rotate = 1'b1;
                        end
                    end
                    // Reload from the next eligible class in the same cycle so
                    // a credit-exhausted switch costs no bubble.
                    if (rotate) begin
                        ptr_nxt = cur + 2'd1;
                        if (sel_found) begin
                            cur_nxt    = sel_idx;
                            credit_nxt = weight[sel_idx];
                        end else begin
                            state_nxt  = IDLE;
                            credit_nxt = '0;
                        end
                    end
                end
            end
            STALL: begin
                if (!almost_full) begin
                    state_nxt = SERVE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (reset || init) begin
            pop = '0;
        end
    end

    // State, weights, credit and the popped-word tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            credit    <= '0;
            ptr       <= '0;
            cur       <= '0;
            sel_d     <= '0;
            valid_out <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                weight[k] <= WEIGHT_W'(1);
            end
        end else begin
            valid_out <= |pop;
            if (|pop) begin
                sel_d <= cur;
            end
            if (init) begin
                state  <= IDLE;
                credit <= '0;
                ptr    <= '0;
                for (int unsigned k = 0; k < 4; k++) begin
                    weight[k] <= peso_in[k*WEIGHT_W +: WEIGHT_W];
                end
            end else begin
                state  <= state_nxt;
                credit <= credit_nxt;
                ptr    <= ptr_nxt;
                cur    <= cur_nxt;
            end
        end
    end

    // Output mux: word from the class popped last cycle, zero otherwise.
    always_comb begin
        data_out = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (valid_out && (sel_d == 2'(k))) begin
                data_out = data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_idx = cur;
    assign idle      = (state == IDLE);

endmodule

// File: tb/tb_wrr_scheduler.sv
// Self-checking bench for wrr_scheduler: FIFO environment driven by the DUT's
// pops, plus an independent per-cycle model of the weighted round-robin rules.
module tb_wrr_scheduler;

    localparam int DW = 12;
    localparam int WW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            init;
    logic [4*WW-1:0] peso_in;
    logic [3:0]      empty;
    logic            almost_full;
    logic [4*DW-1:0] data_in;
    logic [3:0]      pop;
    logic [1:0]      grant_idx;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            idle;

    wrr_scheduler #(.DATA_W(DW), .WEIGHT_W(WW)) dut (
        .clk(clk), .reset(reset), .init(init), .peso_in(peso_in),
        .empty(empty), .almost_full(almost_full), .data_in(data_in),
        .pop(pop), .grant_idx(grant_idx), .data_out(data_out),
        .valid_out(valid_out), .idle(idle)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Environment FIFOs (react to DUT pops) and model FIFOs (react to model pops).
    logic [DW-1:0] eq [4][$];
    logic [DW-1:0] mq [4][$];
    bit            env_live;
    logic [3:0]    last_pop;

    // Model of the scheduler rules.
    int            mw [4];
    int            m_credit, m_ptr, m_cur;
    bit            m_busy, m_wait, m_vld;
    logic [DW-1:0] m_word;

    function automatic int pick(int from);
        for (int i = 0; i < 4; i++) begin
            int k = (from + i) % 4;
            if (!empty[k] && mw[k] != 0) return k;
        end
        return -1;
    endfunction

    function automatic int first_idx(logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mw[k] = 1;
        m_credit = 0; m_ptr = 0; m_cur = 0;
        m_busy = 0; m_wait = 0; m_vld = 0; m_word = '0;
    endtask

    task automatic refresh_empty();
        for (int k = 0; k < 4; k++) empty[k] = (eq[k].size() == 0);
    endtask

    task automatic fill(int k, int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {2'(k), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            eq[k].push_back(w);
            mq[k].push_back(w);
        end
        refresh_empty();
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < 4; k++) begin
            eq[k].delete();
            mq[k].delete();
        end
        refresh_empty();
    endtask

    // One clock cycle: predict, compare at settle time, advance model and FIFOs.
    task automatic tick();
        int ep, k;
        bit rot;
        logic [3:0] ep_v;
        bit e_idle, e_valid;
        int e_grant;
        logic [DW-1:0] e_data;
        e_idle  = !m_busy;
        e_grant = m_cur;
        e_valid = m_vld;
        e_data  = m_vld ? m_word : '0;
        ep  = -1;
        rot = 0;
        if (reset) begin
            model_reset();
        end else if (init) begin
            for (int j = 0; j < 4; j++) mw[j] = int'(peso_in[j*WW +: WW]);
            m_ptr = 0; m_credit = 0; m_busy = 0; m_wait = 0;
        end else if (!m_busy) begin
            k = pick(m_ptr);
            if (k >= 0 && !almost_full) begin
                m_busy = 1; m_cur = k; m_credit = mw[k];
            end
        end else if (m_wait) begin
            if (!almost_full) m_wait = 0;
        end else if (almost_full) begin
            m_wait = 1;
        end else begin
            if (empty[m_cur]) begin
                rot = 1;
            end else begin
                ep = m_cur;
                m_credit--;
                if (m_credit == 0) rot = 1;
            end
            if (rot) begin
                m_ptr = (m_cur + 1) % 4;
                k = pick(m_ptr);
                if (k >= 0) begin
                    m_cur = k; m_credit = mw[k];
                end else begin
                    m_busy = 0; m_credit = 0;
                end
            end
        end
        ep_v = (ep >= 0) ? 4'(1 << ep) : 4'b0000;
        #1;
        checks++;
        if (pop !== ep_v) begin
            errors++;
            $display("FAIL pop @%0t: got %b expected %b", $time, pop, ep_v);
        end
        checks++;
        if (valid_out !== e_valid) begin
            errors++;
            $display("FAIL valid_out @%0t: got %b expected %b", $time, valid_out, e_valid);
        end
        checks++;
        if (data_out !== e_data) begin
            errors++;
            $display("FAIL data_out @%0t: got %h expected %h", $time, data_out, e_data);
        end
        checks++;
        if (idle !== e_idle) begin
            errors++;
            $display("FAIL idle @%0t: got %b expected %b", $time, idle, e_idle);
        end
        checks++;
        if (grant_idx !== 2'(e_grant)) begin
            errors++;
            $display("FAIL grant_idx @%0t: got %0d expected %0d", $time, grant_idx, e_grant);
        end
        last_pop = pop;
        @(posedge clk);
        m_vld = (ep >= 0);
        if (ep >= 0) m_word = (mq[ep].size() > 0) ? mq[ep].pop_front() : '0;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            if (last_pop[j] && eq[j].size() > 0) data_in[j*DW +: DW] = eq[j].pop_front();
        end
        if (env_live) refresh_empty();
    endtask

    task automatic do_init(int w0, int w1, int w2, int w3);
        peso_in = {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic test_reset();
        env_live = 0;
        reset = 1'b1; init = 1'b0; almost_full = 1'b0;
        peso_in = '0; empty = 4'b0000; data_in = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        env_live = 1;
        clear_fifos();
    endtask

    task automatic test_weighted();
        int seq[$];
        int exp_seq[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        do_init(3, 1, 2, 1);
        for (int k = 0; k < 4; k++) fill(k, 8);
        for (int c = 0; c < 11; c++) begin
            tick();
            if (last_pop != 4'b0000) seq.push_back(first_idx(last_pop));
        end
        checks++;
        if (seq.size() != 10) begin
            errors++;
            $display("FAIL weighted_gapless_count: got %0d expected 10", seq.size());
        end
        for (int i = 0; i < 10 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL weighted_seq[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_two_classes();
        int bad = 0;
        do_init(2, 2, 2, 2);
        clear_fifos();
        fill(1, 6);
        fill(3, 6);
        for (int c = 0; c < 16; c++) begin
            tick();
            if (last_pop[0] || last_pop[2]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL two_classes_forbidden_pop: got %0d expected 0", bad);
        end
    endtask

    task automatic test_backpressure();
        int seq[$];
        int stalled_pops = 0;
        do_init(3, 1, 2, 1);
        clear_fifos();
        for (int k = 0; k < 4; k++) fill(k, 8);
        repeat (3) tick();           // IDLE->SERVE, then two pops of class 0
        almost_full = 1'b1;
        repeat (3) begin
            tick();
            if (last_pop != 4'b0000) stalled_pops++;
        end
        almost_full = 1'b0;
        checks++;
        if (stalled_pops != 0) begin
            errors++;
            $display("FAIL backpressure_pop_while_full: got %0d expected 0", stalled_pops);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (last_pop != 4'b0000) seq.push_back(first_idx(last_pop));
        end
        checks++;
        if (seq.size() < 2 || seq[0] != 0 || seq[1] != 1) begin
            errors++;
            $display("FAIL backpressure_resume: got %p expected first two 0,1", seq);
        end
    endtask

    task automatic test_empty_skip();
        int pops2 = 0;
        do_init(1, 1, 4, 1);
        clear_fifos();
        fill(0, 8); fill(1, 8); fill(2, 2); fill(3, 8);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (last_pop[2]) pops2++;
        end
        checks++;
        if (pops2 != 2) begin
            errors++;
            $display("FAIL empty_skip_class2_pops: got %0d expected 2", pops2);
        end
    endtask

    task automatic test_init_mid_burst();
        int pops1 = 0;
        int first = -1;
        do_init(4, 4, 4, 4);
        clear_fifos();
        for (int k = 0; k < 4; k++) fill(k, 8);
        repeat (3) tick();
        do_init(2, 0, 3, 1);
        for (int c = 0; c < 16; c++) begin
            tick();
            if (last_pop[1]) pops1++;
            if (first < 0 && last_pop != 4'b0000) first = first_idx(last_pop);
        end
        checks++;
        if (pops1 != 0) begin
            errors++;
            $display("FAIL init_weight0_pops: got %0d expected 0", pops1);
        end
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL init_restart_class: got %0d expected 0", first);
        end
    endtask

    task automatic test_random();
        clear_fifos();
        for (int c = 0; c < 2000; c++) begin
            almost_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) fill($urandom_range(0, 3), $urandom_range(1, 6));
            init  = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 499) == 0);
            if (init) peso_in = 12'($urandom);
            tick();
        end
        reset = 1'b0; init = 1'b0; almost_full = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_weighted();
        test_two_classes();
        test_backpressure();
        test_empty_skip();
        test_init_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wrr_scheduler.md
Name: wrr_scheduler

Overview:
Weighted round-robin scheduler that drains the four class (VC) FIFOs into the single merge FIFO ahead of the destination router. It drives the class-FIFO read enables one-hot, honours downstream almost_full backpressure, and multiplexes the popped word onto a single data/valid stream. Per-class weights are loaded by the configuration FSM through `init`, the same way the umbrales are.

Parameters:
DATA_W, 12, width of one data word (class[11:10], dest[9:8], payload[7:0])
WEIGHT_W, 3, width of each per-class weight/credit (max burst 2^WEIGHT_W-1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
init  input  1  load weights from peso_in; restart scheduling
peso_in  input  4*WEIGHT_W  packed weights, class k at [k*WEIGHT_W +: WEIGHT_W]
empty  input  4  empty flags of class FIFOs 0..3
almost_full  input  1  almost_full of downstream merge FIFO
data_in  input  4*DATA_W  packed class-FIFO data_out, class k at [k*DATA_W +: DATA_W]
pop  output  4  one-hot read enable to class FIFOs (all-zero when idle)
grant_idx  output  2  class currently holding the grant
data_out  output  DATA_W  word popped on the previous cycle
valid_out  output  1  data_out valid; drives merge FIFO write_enable
idle  output  1  high in IDLE state

Behaviour:
- Reset (synchronous, clk, reset active-high): weights all 1, credit 0, ptr 0, state IDLE; pop=0, grant_idx=0, data_out=0, valid_out=0, idle=1.
- Eligibility: class k is eligible when empty[k]=0 and weight[k]!=0. A weight-0 class is never served.
- Selection: next class is the first eligible class scanning ptr, ptr+1, … mod 4. Selection is combinational, so switching classes costs no bubble cycle.
- States:
  - IDLE: pop=0. If any class is eligible and almost_full=0 -> SERVE, with cur=selected class and credit=weight[cur].
  - SERVE:
    - If almost_full=1 -> STALL; no pop; credit held.
    - Else pop[cur]=1 and credit decrements.
    - When credit reaches 0 after this pop, or empty[cur]=1 at the start of the cycle (remaining credit forfeited, no pop to cur): ptr=cur+1 (3 wraps to 0), reselect.
      - If a class is eligible: cur/credit reload, stay in SERVE.
      - Otherwise -> IDLE.
  - STALL: pop=0. When almost_full=0 -> SERVE with the same cur and remaining credit. If cur emptied meanwhile, the SERVE empty rule applies.
- Simultaneous events:
  - almost_full=1 in the same cycle as the last credit: stall wins, credit stays 1.
  - empty[cur] rising while almost_full=1: handled on return to SERVE.
- pop is never asserted to a class with empty=1 and never while almost_full=1. At most one pop bit is set.
- Datapath: the class FIFO presents its word one cycle after read_enable.
  - valid_out is pop-OR registered (1-cycle latency).
  - sel_d is the registered index of the popped class.
  - data_out = data_in[sel_d] when valid_out=1, else 0.
- init (any state, priority below reset):
  - weights <= peso_in, ptr=0, credit=0, state -> IDLE, pop=0 that cycle.
  - valid_out still reflects a pop from the previous cycle; no word is lost.
- grant_idx = cur in SERVE/STALL; holds its last value in IDLE.
- Throughput: 1 word/cycle while eligible and not backpressured.

Test Plan:
- Reset: reset=1 for 2 cycles with empty=4'b0000 -> pop=0, valid_out=0, data_out=0, idle=1, grant_idx=0 throughout.
- Weights 3,1,2,1 via init; all FIFOs holding 8 words, almost_full=0 -> pop sequence 0,0,0,1,2,2,3,0,0,0,… with no gap. valid_out trails pop by 1 cycle. data_out class bits match sel_d.
- Weights 2,2,2,2; only FIFOs 1 and 3 non-empty -> pop 1,1,3,3,1,1, and FIFO 0/2 pop bits never set.
- almost_full raised on the cycle class 0 has credit 1 left, held 3 cycles -> pop=0 for those 3 cycles, idle=0. After release, exactly one more pop[0], then class 1.
- Class 2 (weight 4) empties after 2 pops -> next cycle pop moves to class 3, and class 2 is skipped on the next rotation while empty=1.
- Weight 0 on class 1; init asserted mid-burst -> state returns to IDLE, ptr=0, new weights used. Class 1 is never popped even with data.
